// File: rtl/instr_dcd_burst_if.sv
// rtl/instr_dcd_burst_if.sv - SPI byte side and register-file side of the burst decoder
interface instr_dcd_burst_if #(
  parameter int ADDR_W = 6
);
  logic              frame;
  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              busy;
  logic              addr_err;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_read;
  logic [7:0]        data_write;

  modport slave (
    input  frame, byte_sync, data_in, data_read,
    output data_out, busy, addr_err, read, write, addr, data_write
  );

  modport master (
    output frame, byte_sync, data_in, data_read,
    input  data_out, busy, addr_err, read, write, addr, data_write
  );
endinterface

// File: rtl/instr_dcd_burst.sv
// rtl/instr_dcd_burst.sv - SPI header/burst decoder and register-access sequencer
module instr_dcd_burst #(
  parameter int         ADDR_W   = 6,
  parameter logic [5:0] MAX_ADDR = 6'h0A,
  parameter bit         WRAP     = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  instr_dcd_burst_if.slave bus
);
  typedef enum logic [1:0] {S_HDR, S_RD, S_WR, S_DATA} state_t;

  localparam logic [6:0] MAX_EXT = {1'b0, MAX_ADDR};

  state_t            state_q;
  logic              rw_q;
  logic              inc_q;
  logic              bad_q;
  logic              adv_pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_out_q;
  logic [7:0]        data_write_q;
  logic              read_q;
  logic              write_q;
  logic              busy_q;
  logic              err_q;

  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_bad;
  logic [ADDR_W-1:0] addr_nxt;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {{(7-ADDR_W){1'b0}}, a} <= MAX_EXT;
  endfunction

  // Past MAX_ADDR without wrap the address parks out of range until the frame ends.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    logic [6:0] a_ext;
    a_ext = {{(7-ADDR_W){1'b0}}, a};
    if (a_ext == MAX_EXT) begin
      if (WRAP) return '0;
      return a + ADDR_W'(1);
    end
    if (!WRAP && (a_ext > MAX_EXT)) return a;
    return a + ADDR_W'(1);
  endfunction

  always_comb begin
    hdr_addr = bus.data_in[ADDR_W-1:0];
    hdr_bad  = (bus.data_in[5:0] >> ADDR_W) != 6'd0;
    addr_nxt = inc_q ? next_addr(addr_q) : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      rw_q         <= 1'b0;
      inc_q        <= 1'b0;
      bad_q        <= 1'b0;
      adv_pend_q   <= 1'b0;
      addr_q       <= '0;
      data_out_q   <= 8'h00;
      data_write_q <= 8'h00;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;

      // A write advances the address the cycle after its strobe so addr stays valid with write.
      if (adv_pend_q) begin
        addr_q     <= addr_nxt;
        adv_pend_q <= 1'b0;
      end

      // A read strobe in flight always lands its data, even if the frame closes now.
      if (read_q) data_out_q <= bus.data_read;

      if (!bus.frame) begin
        state_q <= S_HDR;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_HDR: begin
            if (bus.byte_sync) begin
              rw_q   <= bus.data_in[7];
              inc_q  <= bus.data_in[6];
              addr_q <= hdr_addr;
              busy_q <= 1'b1;
              if (hdr_bad) begin
                bad_q      <= 1'b1;
                err_q      <= 1'b1;
                data_out_q <= 8'h00;
                state_q    <= S_DATA;
              end else if (bus.data_in[7]) begin
                bad_q      <= 1'b0;
                data_out_q <= 8'h00;
                state_q    <= S_WR;
              end else begin
                bad_q   <= 1'b0;
                read_q  <= in_range(hdr_addr);
                err_q   <= !in_range(hdr_addr);
                state_q <= S_RD;
              end
            end
          end

          S_RD: begin
            if (!read_q) data_out_q <= 8'h00;
            state_q <= S_DATA;
          end

          S_WR, S_DATA: begin
            if (bus.byte_sync) begin
              if (bad_q) begin
                data_out_q <= 8'h00;
              end else if (rw_q) begin
                data_out_q <= 8'h00;
                adv_pend_q <= 1'b1;
                state_q    <= S_DATA;
                if (in_range(addr_q)) begin
                  write_q      <= 1'b1;
                  data_write_q <= bus.data_in;
                end else begin
                  err_q <= 1'b1;
                end
              end else begin
                // Prefetch the byte for the next slot.
                addr_q  <= addr_nxt;
                read_q  <= in_range(addr_nxt);
                err_q   <= !in_range(addr_nxt);
                state_q <= S_RD;
              end
            end
          end

          default: state_q <= S_HDR;
        endcase
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.addr       = addr_q;
  assign bus.data_write = data_write_q;
  assign bus.busy       = busy_q;
  assign bus.addr_err   = err_q;
endmodule

// File: tb/tb_instr_dcd_burst.sv
// tb/tb_instr_dcd_burst.sv - directed scoreboard bench for instr_dcd_burst
module tb_instr_dcd_burst;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame = 1'b0;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;

  always #5 clk = ~clk;

  instr_dcd_burst_if #(.ADDR_W(6)) if_a ();
  instr_dcd_burst_if #(.ADDR_W(6)) if_b ();
  instr_dcd_burst_if #(.ADDR_W(4)) if_c ();

  assign if_a.frame = frame;
  assign if_a.byte_sync = byte_sync;
  assign if_a.data_in = data_in;
  assign if_a.data_read = 8'h10 + {2'b00, if_a.addr};
  assign if_b.frame = frame;
  assign if_b.byte_sync = byte_sync;
  assign if_b.data_in = data_in;
  assign if_b.data_read = 8'h10 + {2'b00, if_b.addr};
  assign if_c.frame = frame;
  assign if_c.byte_sync = byte_sync;
  assign if_c.data_in = data_in;
  assign if_c.data_read = 8'h10 + {4'h0, if_c.addr};

  instr_dcd_burst #(.ADDR_W(6), .MAX_ADDR(6'h0A), .WRAP(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  instr_dcd_burst #(.ADDR_W(6), .MAX_ADDR(6'h0A), .WRAP(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  instr_dcd_burst #(.ADDR_W(4), .MAX_ADDR(6'h0A), .WRAP(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  int n_asserts = 0;
  int n_fail = 0;
  int tgt = 0;
  logic [16:0] exp_q[$];

  logic       m_read, m_write, m_err, m_busy;
  logic [5:0] m_addr;
  logic [7:0] m_dw, m_dout;

  always_comb begin
    case (tgt)
      1: begin
        m_read = if_b.read; m_write = if_b.write; m_err = if_b.addr_err; m_busy = if_b.busy;
        m_addr = if_b.addr; m_dw = if_b.data_write; m_dout = if_b.data_out;
      end
      2: begin
        m_read = if_c.read; m_write = if_c.write; m_err = if_c.addr_err; m_busy = if_c.busy;
        m_addr = {2'b00, if_c.addr}; m_dw = if_c.data_write; m_dout = if_c.data_out;
      end
      default: begin
        m_read = if_a.read; m_write = if_a.write; m_err = if_a.addr_err; m_busy = if_a.busy;
        m_addr = if_a.addr; m_dw = if_a.data_write; m_dout = if_a.data_out;
      end
    endcase
  end

  function automatic logic [16:0] ev(input logic r, input logic w, input logic e,
                                     input logic [5:0] a, input logic [7:0] d);
    return {r, w, e, a, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Every strobe or error pulse of the selected instance must match the next expected event.
  always @(negedge clk) begin
    logic [16:0] obs, exp_ev;
    if (rst_n && (m_read || m_write || m_err)) begin
      obs = ev(m_read, m_write, m_err, (m_read || m_write) ? m_addr : 6'd0, m_write ? m_dw : 8'd0);
      n_asserts++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_event: observed 0x%0h expected none", obs);
      end
      if (exp_q.size() > 0) begin
        exp_ev = exp_q.pop_front();
        n_asserts++;
        assert (obs === exp_ev) else begin
          n_fail++;
          $error("FAIL event: observed 0x%0h expected 0x%0h", obs, exp_ev);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    byte_sync = 1'b1;
    @(negedge clk);
    byte_sync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_on();
    @(negedge clk);
    frame = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_off();
    @(negedge clk);
    frame = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {m_read, m_write, m_err, m_busy, m_addr, m_dw, m_dout}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write
    tgt = 0;
    frame_on();
    send(8'h83);
    chk("wr_busy", m_busy, 1);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 6'd3, 8'h5A));
    send(8'h5A);
    chk("wr_dout", m_dout, 8'h00);
    frame_off();
    chk("wr_busy_end", m_busy, 0);
    drain("wr_drain");

    // Read burst with auto-increment and wrap
    frame_on();
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 6'd8, 8'h00));
    send(8'h48);
    chk("rd_dout0", m_dout, 8'h18);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 6'd9, 8'h00));
    send(8'h00);
    chk("rd_dout1", m_dout, 8'h19);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 6'd10, 8'h00));
    send(8'h00);
    chk("rd_dout2", m_dout, 8'h1A);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 6'd0, 8'h00));
    send(8'h00);
    chk("rd_dout_wrap", m_dout, 8'h10);
    frame_off();
    drain("rd_drain");

    // Read header addressing beyond MAX_ADDR
    frame_on();
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 6'd0, 8'h00));
    send(8'h0C);
    chk("rd_oor_dout", m_dout, 8'h00);
    frame_off();
    drain("rd_oor_drain");

    // Saturating write burst
    tgt = 1;
    frame_on();
    send(8'hCA);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 6'd10, 8'h01));
    send(8'h01);
    chk("sat_addr", m_addr, 6'd11);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 6'd0, 8'h00));
    send(8'h02);
    frame_off();
    drain("sat_drain");

    // Fixed-address write burst
    tgt = 0;
    frame_on();
    send(8'h82);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 6'd2, 8'h11));
    send(8'h11);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 6'd2, 8'h22));
    send(8'h22);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 6'd2, 8'h33));
    send(8'h33);
    chk("fix_addr", m_addr, 6'd2);
    frame_off();
    drain("fix_drain");

    // Frame abort after a read header, then a write frame
    frame_on();
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 6'd5, 8'h00));
    send(8'h45);
    chk("abort_dout", m_dout, 8'h15);
    @(negedge clk);
    frame = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", m_busy, 0);
    frame_on();
    send(8'h81);
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 6'd1, 8'hAA));
    send(8'hAA);
    chk("abort_wr_dout", m_dout, 8'h00);
    frame_off();
    drain("abort_drain");

    // Byte with frame low is ignored
    send(8'h83);
    chk("noframe_busy", m_busy, 0);
    drain("noframe_drain");

    // Reset mid-burst, then a malformed header on the narrow instance
    tgt = 2;
    frame_on();
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 6'd2, 8'h00));
    send(8'h42);
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 6'd3, 8'h00));
    send(8'h00);
    chk("mid_dout", m_dout, 8'h13);
    chk("mid_busy", m_busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {m_read, m_write, m_err, m_busy, m_addr, m_dw, m_dout}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 6'd0, 8'h00));
    send(8'h30);
    chk("bad_busy", m_busy, 1);
    send(8'h55);
    send(8'h66);
    chk("bad_dout", m_dout, 8'h00);
    frame_off();
    drain("bad_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
